message_tx_sequencer: RTL and testbench

- Sequences a fixed-length message source (an 8-bit byte on `i_data`, advanced by a rising edge on `o_get_next`) into a byte-wide serial transmitter that uses a valid/ready handshake.
- Sits between the message source and the UART TX.
- Fetches each byte, hands it to the transmitter, advances the source, and inserts a programmable idle gap between messages while `i_enable` is high.
- Keeps its own message position so that it stays aligned with the source, which has no reset.

---
 rtl/message_tx_sequencer_if.sv | 24 ++
 rtl/message_tx_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_message_tx_sequencer.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/message_tx_sequencer_if.sv
// Byte-wide transmit channel between message_tx_sequencer and a serial
// transmitter such as a UART TX.
//
// Handshake: a byte moves on every rising clock edge where o_tx_valid and
// i_tx_ready are both high. Once o_tx_valid is raised, it and o_tx_data
// stay unchanged until that transfer happens. i_tx_ready may change freely
// and has no combinational effect on o_tx_valid.
interface message_tx_sequencer_if;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;

    modport master (
        output o_tx_data,
        output o_tx_valid,
        input  i_tx_ready
    );

    modport slave (
        input  o_tx_data,
        input  o_tx_valid,
        output i_tx_ready
    );
endinterface

// File: rtl/message_tx_sequencer.sv
// message_tx_sequencer: walks a fixed-length, reset-less message source
// byte by byte into a valid/ready transmitter. An idle gap of GAP_CYCLES
// clocks is inserted between messages. The module tracks the source index
// in its own pos counter, so it can re-align the source after a reset.
//
// Optional feature macro: MSG_TX_CRLF_EN appends 8'h0D 8'h0A after each
// message.
//
// All outputs are registered. Next-state and next-output values are
// computed together and captured on the same clock edge.
module message_tx_sequencer #(
    parameter int MSG_LEN    = 14,
    parameter int GAP_CYCLES = 1200
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_enable,
    input  logic [7:0]                    i_data,
    output logic                          o_get_next,
    output logic                          o_active,
    output logic                          o_msg_done,
    output logic [2:0]                    o_dbg_state,
    message_tx_sequencer_if.master        tx
);

    localparam int PW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [PW-1:0] POS_LAST = PW'(MSG_LEN - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SEND    = 3'd1,
        S_ADVANCE = 3'd2,
        S_SETTLE  = 3'd3,
`ifdef MSG_TX_CRLF_EN
        S_CR      = 3'd4,
        S_LF      = 3'd5,
`endif
        S_GAP     = 3'd6,
        S_RESYNC  = 3'd7
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [GW-1:0] gap_cnt;
    logic [GW-1:0] gap_cnt_n;
    logic [7:0]    tx_data_n;
    logic          tx_valid_n;
    logic          get_next_n;
    logic          msg_done_n;

    // The source has no reset, so pos is deliberately not reset either.
    // It starts at 0 at power-up, matching the source.
    logic [PW-1:0] pos = '0;

    assign o_dbg_state = state;

    // Advance the source index on every pulse, including one in flight during reset.
    always_ff @(posedge i_clk) begin
        if (o_get_next) begin
            pos <= (pos == POS_LAST) ? '0 : pos + PW'(1);
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_n    = state;
        gap_cnt_n  = gap_cnt;
        tx_data_n  = tx.o_tx_data;
        get_next_n = 1'b0;
        msg_done_n = 1'b0;
        case (state)
            S_IDLE: begin
                if (pos != '0) begin
                    state_n    = S_RESYNC;
                    get_next_n = 1'b1;
                end else if (i_enable) begin
                    tx_data_n = i_data;
                    state_n   = S_SEND;
                end
            end
            S_SEND: begin
                if (tx.i_tx_ready) begin
                    state_n    = S_ADVANCE;
                    get_next_n = 1'b1;
`ifndef MSG_TX_CRLF_EN
                    if (pos == POS_LAST) begin
                        msg_done_n = 1'b1;
                    end
`endif
                end
            end
            S_ADVANCE: begin
                // pos still holds the index of the byte just sent; it
                // updates on this same edge.
                if (pos == POS_LAST) begin
`ifdef MSG_TX_CRLF_EN
                    state_n   = S_CR;
                    tx_data_n = 8'h0D;
`else
                    state_n   = S_GAP;
                    gap_cnt_n = '0;
`endif
                end else begin
                    state_n = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The source moved on the get_next edge; i_data now shows the next byte.
                tx_data_n = i_data;
                state_n   = S_SEND;
            end
`ifdef MSG_TX_CRLF_EN
            S_CR: begin
                if (tx.i_tx_ready) begin
                    state_n   = S_LF;
                    tx_data_n = 8'h0A;
                end
            end
            S_LF: begin
                if (tx.i_tx_ready) begin
                    state_n    = S_GAP;
                    gap_cnt_n  = '0;
                    msg_done_n = 1'b1;
                end
            end
`endif
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_n = '0;
                    if (i_enable) begin
                        tx_data_n = i_data;
                        state_n   = S_SEND;
                    end else begin
                        state_n = S_IDLE;
                    end
                end else begin
                    gap_cnt_n = gap_cnt + GW'(1);
                end
            end
            S_RESYNC: begin
                // One high cycle, then one low cycle, per source step. The
                // low cycle lets pos settle before it is tested.
                if (!o_get_next) begin
                    if (pos == '0) begin
                        state_n = S_IDLE;
                    end else begin
                        get_next_n = 1'b1;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
`ifdef MSG_TX_CRLF_EN
        tx_valid_n = (state_n == S_SEND) || (state_n == S_CR) || (state_n == S_LF);
`else
        tx_valid_n = (state_n == S_SEND);
`endif
    end

    // State and output registers. Reset drops any byte that is offered but not yet accepted.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state          <= S_IDLE;
            gap_cnt        <= '0;
            tx.o_tx_data   <= 8'h00;
            tx.o_tx_valid  <= 1'b0;
            o_get_next     <= 1'b0;
            o_msg_done     <= 1'b0;
            o_active       <= 1'b0;
        end else begin
            state          <= state_n;
            gap_cnt        <= gap_cnt_n;
            tx.o_tx_data   <= tx_data_n;
            tx.o_tx_valid  <= tx_valid_n;
            o_get_next     <= get_next_n;
            o_msg_done     <= msg_done_n;
            o_active       <= (state_n != S_IDLE);
        end
    end

endmodule

// File: tb/tb_message_tx_sequencer.sv
// Testbench for message_tx_sequencer. A behavioural source returns
// "Hello, world! " and steps on each rising edge of o_get_next. Expected
// bytes are queued when a message is requested, then popped as the
// transmitter accepts bytes.
module tb_message_tx_sequencer;

    localparam int MSG_LEN = 14;
    localparam int GAP     = 8;
`ifdef MSG_TX_CRLF_EN
    localparam int MSG_BYTES = 16;
`else
    localparam int MSG_BYTES = 14;
`endif

    // ---------------- clock / reset ----------------
    logic       i_clk    = 1'b0;
    logic       i_rst    = 1'b1;
    logic       i_enable = 1'b0;
    logic [7:0] i_data;
    logic       o_get_next;
    logic       o_active;
    logic       o_msg_done;
    logic [2:0] o_dbg_state;

    always #5 i_clk = ~i_clk;

    message_tx_sequencer_if tx_if ();

    message_tx_sequencer #(
        .MSG_LEN    (MSG_LEN),
        .GAP_CYCLES (GAP)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_data      (i_data),
        .o_get_next  (o_get_next),
        .o_active    (o_active),
        .o_msg_done  (o_msg_done),
        .o_dbg_state (o_dbg_state),
        .tx          (tx_if)
    );

    // ---------------- behavioural message source (no reset) ----------------
    logic [7:0] rom [14] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h2C, 8'h20,
                             8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21, 8'h20};
    int src_idx = 0;
    assign i_data = rom[src_idx];
    always @(posedge o_get_next) src_idx <= (src_idx == MSG_LEN - 1) ? 0 : src_idx + 1;

    // ---------------- scoreboard state ----------------
    logic [7:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ready_mode = 0;   // 0: always ready, 1: random stalls, 2: held low
    int stall_left = 0;
    int hs_count = 0;
    int gn_count = 0;
    int md_count = 0;
    int byte_idx = 0;
    int first_hs_cyc = 0;
    int data_last_cyc = 0;
    int frame_last_cyc = 0;
    int md_cyc = 0;
    logic       gn_prev = 1'b0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_msg();
        for (int i = 0; i < MSG_LEN; i++) exp_q.push_back(rom[i]);
`ifdef MSG_TX_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    // ---------------- driver + monitor, one clock per call ----------------
    task automatic tick();
        logic [7:0] e;
        @(negedge i_clk);
        cyc++;
        case (ready_mode)
            0: tx_if.i_tx_ready = 1'b1;
            1: begin
                if (stall_left > 0) begin
                    tx_if.i_tx_ready = 1'b0;
                    stall_left--;
                end else begin
                    tx_if.i_tx_ready = 1'b1;
                end
            end
            default: tx_if.i_tx_ready = 1'b0;
        endcase
        if (tx_if.o_tx_valid === 1'b1 && prev_valid && !prev_ready)
            check("data_stable", tx_if.o_tx_data, prev_data);
        if (tx_if.o_tx_valid === 1'b1 && tx_if.i_tx_ready) begin
            if (exp_q.size() == 0) begin
                check("byte_expected", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("byte", tx_if.o_tx_data, e);
            end
            if (byte_idx == 0) first_hs_cyc = cyc;
            if (byte_idx == MSG_LEN - 1) data_last_cyc = cyc;
            if (byte_idx == MSG_BYTES - 1) frame_last_cyc = cyc;
            byte_idx = (byte_idx == MSG_BYTES - 1) ? 0 : byte_idx + 1;
            hs_count++;
            if (ready_mode == 1) stall_left = $urandom_range(0, 5);
        end
        if (o_get_next === 1'b1 && !gn_prev) gn_count++;
        gn_prev = (o_get_next === 1'b1);
        if (o_msg_done === 1'b1) begin
            md_count++;
            md_cyc = cyc;
        end
        prev_valid = (tx_if.o_tx_valid === 1'b1);
        prev_ready = tx_if.i_tx_ready;
        prev_data  = tx_if.o_tx_data;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        int n;
        start = md_count;
        n = 0;
        while (md_count == start && n < budget) begin
            tick();
            n++;
        end
        check(tag, md_count - start, 1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int gn0;
        int hs0;
        int n;
        int act;
        int vcnt;
        int chg;
        tx_if.i_tx_ready = 1'b1;

        // Reset state
        i_rst = 1'b1;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check("rst_valid", tx_if.o_tx_valid, 0);
        check("rst_get_next", o_get_next, 0);
        check("rst_msg_done", o_msg_done, 0);
        check("rst_active", o_active, 0);
        check("rst_data", tx_if.o_tx_data, 8'h00);
        check("rst_state", o_dbg_state, 0);

        // Message 1, ready always high
        push_msg();
        gn0 = gn_count;
        i_enable = 1'b1;
        tick();
        check("first_valid", tx_if.o_tx_valid, 1);
        check("first_data", tx_if.o_tx_data, 8'h48);
        wait_done("msg1_done", 200);
        check("byte_spacing", data_last_cyc - first_hs_cyc, 3 * (MSG_LEN - 1));
        check("done_after_last", md_cyc - frame_last_cyc, 1);
        check("msg1_get_next", gn_count - gn0, MSG_LEN);

        // Message 2, random ready stalls; gap length checked on the way in
        push_msg();
        gn0 = gn_count;
        ready_mode = 1;
        stall_left = 0;
        n = 0;
        while (tx_if.o_tx_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check("gap_len", cyc - md_cyc, GAP + 1);
        wait_done("msg2_done", 600);
        check("msg2_get_next", gn_count - gn0, MSG_LEN);

        // Message 3, enable dropped after the fifth handshake
        push_msg();
        ready_mode = 0;
        gn0 = gn_count;
        hs0 = hs_count;
        n = 0;
        while (hs_count - hs0 < 5 && n < 100) begin
            tick();
            n++;
        end
        check("five_bytes", hs_count - hs0, 5);
        i_enable = 1'b0;
        wait_done("msg3_done", 200);
        repeat (GAP + 3) tick();
        check("idle_active", o_active, 0);
        check("idle_state", o_dbg_state, 0);
        check("idle_valid", tx_if.o_tx_valid, 0);
        check("msg3_all_sent", exp_q.size(), 0);
        check("msg3_get_next", gn_count - gn0, MSG_LEN);

        // Stall at pos=6, hold ready low, then reset mid-handshake
        push_msg();
        i_enable = 1'b1;
        hs0 = hs_count;
        n = 0;
        while (hs_count - hs0 < 6 && n < 100) begin
            tick();
            n++;
        end
        ready_mode = 2;
        i_enable = 1'b0;
        repeat (3) tick();
        check("stall_valid", tx_if.o_tx_valid, 1);
        check("stall_data", tx_if.o_tx_data, 8'h20);
        gn0 = gn_count;
        chg = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (o_dbg_state !== 3'd1 || tx_if.o_tx_valid !== 1'b1) chg++;
        end
        check("stall_hold", chg, 0);
        check("stall_no_get_next", gn_count - gn0, 0);
        i_rst = 1'b1;
        tick();
        check("mid_rst_valid", tx_if.o_tx_valid, 0);
        check("mid_rst_get_next", o_get_next, 0);
        check("mid_rst_msg_done", o_msg_done, 0);
        check("mid_rst_active", o_active, 0);
        check("mid_rst_data", tx_if.o_tx_data, 8'h00);
        exp_q.delete();
        byte_idx = 0;
        i_rst = 1'b0;
        gn0 = gn_count;
        act = 0;
        vcnt = 0;
        for (int i = 0; i < 24; i++) begin
            tick();
            if (o_active === 1'b1) act++;
            if (tx_if.o_tx_valid !== 1'b0) vcnt++;
        end
        check("resync_cycles", act, 2 * (MSG_LEN - 6));
        check("resync_pulses", gn_count - gn0, MSG_LEN - 6);
        check("resync_no_valid", vcnt, 0);
        check("resync_idle", o_dbg_state, 0);

        // Re-enable after resync: starts at the first byte again
        push_msg();
        ready_mode = 1;
        stall_left = 0;
        i_enable = 1'b1;
        tick();
        check("restart_valid", tx_if.o_tx_valid, 1);
        check("restart_data", tx_if.o_tx_data, 8'h48);
        wait_done("msg4_done", 600);
        i_enable = 1'b0;
        repeat (GAP + 3) tick();
        check("final_all_sent", exp_q.size(), 0);
        check("final_active", o_active, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
